activation_requant_collector: RTL
=================================

# activation_requant_collector

Downstream companion to the neuron/MAC stage. Accepts one signed accumulator result per cycle from the layer's neurons, in neuron order. Each result gets ReLU, an arithmetic right-shift requantisation, and saturation to the next layer's signed input width. The results are packed into a flattened layer-output vector, a running argmax is tracked, and completion is signalled with a hold-until-acknowledged handshake to the layer controller.

## Interface
- `N_NEURONS`, 32: results per layer; index counter is `$clog2(N_NEURONS)` bits.
- `WIDTH_IN`, 32: signed width of each incoming neuron result.
- `WIDTH_OUT`, 8: signed width of each stored activation.
- `SHIFT`, 8: requantisation right-shift amount, ≥1.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `layer_start`  in  1  pulse; starts collection of a new layer (accepted only in IDLE).
- `in_valid`  in  1  `in_data` carries the next neuron result.
- `in_data`  in  WIDTH_IN  signed neuron result.
- `in_ready`  out  1  high exactly while in COLLECT.
- `layer_data`  out  WIDTH_OUT*N_NEURONS  flattened activations; entry k at bits `[(k+1)*WIDTH_OUT-1 -: WIDTH_OUT]`.
- `argmax_index`  out  `$clog2(N_NEURONS)`  index of largest raw `in_data` this layer.
- `layer_done`  out  1  high in DONE until acknowledged.
- `layer_ack`  in  1  consumer acknowledge of `layer_done`.

## Operation
- **States:** IDLE, COLLECT, DONE.
  - IDLE: `layer_start` moves to COLLECT.
  - COLLECT: stays until the accept with index == N_NEURONS-1, then moves to DONE.
  - DONE: `layer_done && layer_ack` moves to IDLE.
- **On `layer_start` accept:**
  - index ← 0, `layer_data` ← 0, `argmax_index` ← 0.
  - Running max ← most-negative WIDTH_IN value.
- **Accept:** `in_valid && in_ready`. On accept, entry[index] ← q(`in_data`) and index increments.
- **Requantisation q(x):**
  - x < 0 → 0 (ReLU).
  - Otherwise y = x >>> SHIFT (see Configuration for rounding).
  - If y > 2^(WIDTH_OUT-1)-1 → saturate to 2^(WIDTH_OUT-1)-1, else y.
  - Intermediates are WIDTH_IN+1 bits, so the rounding add cannot overflow.
- **Argmax:**
  - Compares the raw signed `in_data`, not q(x).
  - Update only on strictly greater, so the first occurrence wins ties.
  - The first accept always updates.
- **Ignored inputs:**
  - `in_valid` is ignored outside COLLECT.
  - `layer_start` is ignored in COLLECT and DONE.
  - `layer_ack` is ignored outside DONE.
- **Hold:** `layer_data` and `argmax_index` hold their values through DONE and IDLE until the next `layer_start` accept.

## Timing
- **Reset values** (asynchronous on `reset_n` low, any state including mid-COLLECT):
  - State IDLE, index 0.
  - `layer_data` 0, `argmax_index` 0.
  - `layer_done` 0, `in_ready` 0.
- **Start:** `layer_start` sampled high at edge t → `in_ready` high from t+1.
- **Throughput:** one result per cycle. Entry k is visible on `layer_data` the cycle after its accept edge.
- **Completion:** the last accept at edge t → `layer_done` and `in_ready`=0 from t+1; final `argmax_index` and `layer_data` are valid at t+1.
- **Acknowledge:** `layer_ack` sampled high at edge t while `layer_done` → `layer_done` low from t+1. `layer_start` is then accepted no earlier than edge t+1.
- **Minimum layer latency:** `layer_start` to `layer_done` is N_NEURONS+1 cycles with `in_valid` held high.
- **Stalls:** `in_valid` low in COLLECT stalls; no state change and no timeout.
- **Outputs:** all registered except `in_ready`, which decodes the state.

## Configuration
- **Macro:** `ACT_ROUND_EN`.
- **Defined:** round half-up; y = (x + 2^(SHIFT-1)) >>> SHIFT, applied before saturation.
- **Undefined:** truncation; y = x >>> SHIFT.
- ReLU, saturation, argmax and timing are identical in both builds.

## Test plan
All cases use N_NEURONS=4, WIDTH_IN=32, WIDTH_OUT=8, SHIFT=8.
- **Basic layer:** reset, then `layer_start`, then `in_data` 0x100, 0x200, 0x300, 0x400 on consecutive cycles → `layer_data`=0x04030201, `layer_done` high exactly N+1=5 cycles after `layer_start`, `argmax_index`=3.
- **ReLU and saturation:** inputs −5, 0x0001_0000, 0x7FFF_FFFF, 0 → entries 0, 127, 127, 0. `argmax_index`=2 (raw 0x7FFF_FFFF beats 0x0001_0000).
- **Rounding:** input 0x180 → entry 2 with `ACT_ROUND_EN`, entry 1 without. Input 0x17F → 1 in both builds.
- **Stall and tie handling:**
  - Inputs 50, 900, 900, 10 with `in_valid` gaps of 3 cycles → `argmax_index`=1 (first max wins), `layer_done` only after the fourth accept.
  - `in_valid` pulses before `layer_start` → no writes.
- **Handshake:**
  - Hold `layer_ack` low for 10 cycles → `layer_done` stays high and data is stable.
  - `layer_start` during DONE → ignored.
  - Ack → IDLE. A new `layer_start` then clears `layer_data` to 0.
- **Reset mid-operation:** assert `reset_n` low after two accepts → all outputs 0 immediately (asynchronous). After release a full layer completes correctly.

Source files
------------

// File: rtl/activation_requant_collector.sv
// activation_requant_collector
//   Collects one signed neuron result per cycle for a layer. Each result is passed through
//   ReLU, an arithmetic right shift by SHIFT, and saturation to a signed WIDTH_OUT value,
//   then packed into a flattened layer-output vector. The block also tracks a running
//   argmax over the raw inputs and raises layer_done until the controller acknowledges it.
//
//   Build option: define ACT_ROUND_EN for round-half-up requantisation; when it is left
//   undefined the shift truncates.
//
// Ports
//   clk           in   single clock, rising edge
//   reset_n       in   asynchronous active-low reset
//   layer_start   in   starts a new layer (accepted only in IDLE)
//   in_valid      in   in_data carries the next neuron result
//   in_data       in   signed neuron result, WIDTH_IN bits
//   in_ready      out  high while collecting (decoded from state)
//   layer_data    out  flattened activations, entry k at [(k+1)*WIDTH_OUT-1 -: WIDTH_OUT]
//   argmax_index  out  index of the largest raw in_data this layer
//   layer_done    out  high in DONE until layer_ack
//   layer_ack     in   consumer acknowledge of layer_done

module activation_requant_collector #(
   parameter int unsigned N_NEURONS = 32,
   parameter int unsigned WIDTH_IN  = 32,
   parameter int unsigned WIDTH_OUT = 8,
   parameter int unsigned SHIFT     = 8,
   localparam int unsigned IdxW     = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           layer_start,
   input  logic                           in_valid,
   input  logic [WIDTH_IN-1:0]            in_data,
   output logic                           in_ready,
   output logic [WIDTH_OUT*N_NEURONS-1:0] layer_data,
   output logic [IdxW-1:0]                argmax_index,
   output logic                           layer_done,
   input  logic                           layer_ack
);

   localparam logic [1:0] StIdle    = 2'd0;
   localparam logic [1:0] StCollect = 2'd1;
   localparam logic [1:0] StDone    = 2'd2;

   // One extra bit so the rounding add cannot overflow.
   localparam int unsigned ExtW = WIDTH_IN + 1;

   localparam logic signed [ExtW-1:0] SatMax   = ExtW'((64'd1 << (WIDTH_OUT - 1)) - 64'd1);
   localparam logic signed [ExtW-1:0] RoundAdd = ExtW'(64'd1 << (SHIFT - 1));
   localparam logic [IdxW-1:0]        LastIdx  = IdxW'(N_NEURONS - 1);
   localparam logic signed [WIDTH_IN-1:0] MostNeg = {1'b1, {(WIDTH_IN - 1){1'b0}}};

   logic [1:0]                     state_q, state_d;
   logic [IdxW-1:0]                idx_q, idx_d;
   logic [WIDTH_OUT*N_NEURONS-1:0] data_q, data_d;
   logic [IdxW-1:0]                argmax_q, argmax_d;
   logic signed [WIDTH_IN-1:0]     max_q, max_d;
   logic                           done_q, done_d;

   logic signed [ExtW-1:0]         x_ext;
   logic signed [ExtW-1:0]         x_rnd;
   logic signed [ExtW-1:0]         y_shift;
   logic [WIDTH_OUT-1:0]           q_val;
   logic                           accept;

   assign in_ready     = (state_q == StCollect);
   assign accept       = in_valid && in_ready;
   assign layer_data   = data_q;
   assign argmax_index = argmax_q;
   assign layer_done   = done_q;

   // Requantisation: ReLU, shift (optionally rounded), saturate.
   always_comb begin
      x_ext = {in_data[WIDTH_IN-1], in_data};
`ifdef ACT_ROUND_EN
      x_rnd = x_ext + RoundAdd;
`else
      x_rnd = x_ext;
`endif
      y_shift = x_rnd >>> SHIFT;
      if (in_data[WIDTH_IN-1]) begin
         q_val = '0;
      end else if (y_shift > SatMax) begin
         q_val = SatMax[WIDTH_OUT-1:0];
      end else begin
         q_val = y_shift[WIDTH_OUT-1:0];
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      data_d   = data_q;
      argmax_d = argmax_q;
      max_d    = max_q;
      done_d   = done_q;

      case (state_q)
         StIdle: begin
            if (layer_start) begin
               state_d  = StCollect;
               idx_d    = '0;
               data_d   = '0;
               argmax_d = '0;
               max_d    = MostNeg;
            end
         end
         StCollect: begin
            if (accept) begin
               data_d[idx_q*WIDTH_OUT +: WIDTH_OUT] = q_val;
               // Strictly greater keeps the first occurrence on ties; the first accept
               // always updates even if it equals the most-negative seed.
               if (($signed(in_data) > max_q) || (idx_q == '0)) begin
                  max_d    = $signed(in_data);
                  argmax_d = idx_q;
               end
               idx_d = idx_q + 1'b1;
               if (idx_q == LastIdx) begin
                  state_d = StDone;
                  done_d  = 1'b1;
               end
            end
         end
         StDone: begin
            if (layer_ack) begin
               state_d = StIdle;
               done_d  = 1'b0;
            end
         end
         default: begin
            state_d = StIdle;
            done_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= StIdle;
         idx_q    <= '0;
         data_q   <= '0;
         argmax_q <= '0;
         max_q    <= MostNeg;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         data_q   <= data_d;
         argmax_q <= argmax_d;
         max_q    <= max_d;
         done_q   <= done_d;
      end
   end

endmodule
